reorder_buffer: RTL and testbench

- Circular 8-entry reorder buffer holding every issued instruction from decode until in-order commit.
- Allocates the ROB tag that the reservation station and load/store buffer use as `entry`/Q labels.
- Answers operand-tag lookups, captures results from both CDBs, and retires one entry per cycle to the register file and LSB.
- Detects branch mispredicts at commit and drives the global flush and redirect PC.

---
 rtl/reorder_buffer_pkg.sv | 52 +++++
 rtl/reorder_buffer_lookup.sv | 41 ++++
 rtl/reorder_buffer.sv | 186 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizes, op-type codes and small decode helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int ROB_SIZE     = 8;
    localparam int ROB_ID_WIDTH = 4;
    localparam int IDX_W        = $clog2(ROB_SIZE);
    localparam int OP_WIDTH     = 6;
    localparam int VAL_WIDTH    = 32;
    localparam int ADDR_WIDTH   = 32;

    typedef logic [OP_WIDTH-1:0] op_t;

    localparam op_t OP_NOP   = 6'd0;
    localparam op_t OP_LUI   = 6'd1;
    localparam op_t OP_AUIPC = 6'd2;
    localparam op_t OP_JAL   = 6'd3;
    localparam op_t OP_JALR  = 6'd4;
    localparam op_t OP_BEQ   = 6'd5;
    localparam op_t OP_BNE   = 6'd6;
    localparam op_t OP_BLT   = 6'd7;
    localparam op_t OP_BGE   = 6'd8;
    localparam op_t OP_BLTU  = 6'd9;
    localparam op_t OP_BGEU  = 6'd10;
    localparam op_t OP_LW    = 6'd11;
    localparam op_t OP_SB    = 6'd12;
    localparam op_t OP_SH    = 6'd13;
    localparam op_t OP_SW    = 6'd14;
    localparam op_t OP_ADD   = 6'd15;

    // Static per-entry info captured at issue time.
    typedef struct packed {
        op_t                   op;
        logic [4:0]            rd;
        logic                  pred_taken;
        logic [ADDR_WIDTH-1:0] alt_pc;
    } rob_ent_t;

    // Conditional branches only; JAL/JALR targets are resolved at fetch/ALU and never redirect here.
    function automatic logic is_branch(input op_t op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic is_store(input op_t op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    // Slot i carries tag i+1; tag 0 means "no dependency".
    function automatic logic [ROB_ID_WIDTH-1:0] tag_of(input int i);
        return ROB_ID_WIDTH'(i + 1);
    endfunction

endpackage

// File: rtl/reorder_buffer_lookup.sv
// Operand tag lookup: returns a value for a tag from the entry itself or a same-cycle CDB broadcast.
module reorder_buffer_lookup
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_ID_WIDTH-1:0]             label,
    input  logic [ROB_SIZE-1:0]                 busy,
    input  logic [ROB_SIZE-1:0]                 ready,
    input  logic [ROB_SIZE-1:0][VAL_WIDTH-1:0]  vals,
    input  logic                                rs_en,
    input  logic [ROB_ID_WIDTH-1:0]             rs_lab,
    input  logic [VAL_WIDTH-1:0]                rs_val,
    input  logic                                lsb_en,
    input  logic [ROB_ID_WIDTH-1:0]             lsb_lab,
    input  logic [VAL_WIDTH-1:0]                lsb_val,
    output logic                                hit,
    output logic [VAL_WIDTH-1:0]                val
);

    // Lowest priority written first: lsb bypass, then rs bypass, then the stored entry value.
    always_comb begin
        hit = 1'b0;
        val = '0;
        if (label != '0) begin
            if (lsb_en && lsb_lab == label) begin
                hit = 1'b1;
                val = lsb_val;
            end
            if (rs_en && rs_lab == label) begin
                hit = 1'b1;
                val = rs_val;
            end
            for (int i = 0; i < ROB_SIZE; i++) begin
                if (label == tag_of(i) && busy[i] && ready[i]) begin
                    hit = 1'b1;
                    val = vals[i];
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// 8-entry circular reorder buffer: tag allocation, CDB capture, in-order commit, mispredict flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    dec2rob_en,
    input  logic [OP_WIDTH-1:0]     issue_type,
    input  logic [4:0]              issue_rd,
    input  logic                    issue_pred_taken,
    input  logic [ADDR_WIDTH-1:0]   issue_alt_pc,
    output logic [ROB_ID_WIDTH-1:0] newTag,
    output logic                    isFull,
    input  logic [ROB_ID_WIDTH-1:0] label1,
    input  logic [ROB_ID_WIDTH-1:0] label2,
    output logic                    ready1,
    output logic                    ready2,
    output logic [VAL_WIDTH-1:0]    res1,
    output logic [VAL_WIDTH-1:0]    res2,
    input  logic                    rs_cdb_en,
    input  logic [ROB_ID_WIDTH-1:0] rs_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    rs_cdb2val,
    input  logic                    rs_cdb_taken,
    input  logic                    lsb_cdb_en,
    input  logic [ROB_ID_WIDTH-1:0] lsb_cdb2lab,
    input  logic [VAL_WIDTH-1:0]    lsb_cdb2val,
    output logic                    commit_en,
    output logic [ROB_ID_WIDTH-1:0] commit_lab,
    output logic [VAL_WIDTH-1:0]    commit_val,
    output logic [4:0]              commit_rd,
    output logic                    commit_store,
    output logic                    flush,
    output logic [ADDR_WIDTH-1:0]   flush_pc
);

    logic [ROB_SIZE-1:0]                busy_q, busy_d, ready_q, ready_d, taken_q, taken_d;
    logic [ROB_SIZE-1:0][VAL_WIDTH-1:0] val_q, val_d;
    rob_ent_t [ROB_SIZE-1:0]            ent_q, ent_d;
    logic [IDX_W-1:0]                   head_q, head_d, tail_q, tail_d;
    logic [ROB_ID_WIDTH-1:0]            count_q, count_d;
    logic                               commit_en_q, commit_en_d, commit_store_q, commit_store_d;
    logic                               flush_q, flush_d;
    logic [ROB_ID_WIDTH-1:0]            commit_lab_q, commit_lab_d;
    logic [VAL_WIDTH-1:0]               commit_val_q, commit_val_d;
    logic [4:0]                         commit_rd_q, commit_rd_d;
    logic [ADDR_WIDTH-1:0]              flush_pc_q, flush_pc_d;

    logic     issue_ok, commit_fire, mispredict;
    rob_ent_t head_ent;

    // Full is count-based only, so a same-cycle commit never opens a slot for issue.
    assign isFull      = (count_q == ROB_ID_WIDTH'(ROB_SIZE));
    assign newTag      = ROB_ID_WIDTH'(tail_q) + ROB_ID_WIDTH'(1);
    assign issue_ok    = rdy_in && dec2rob_en && !isFull && !flush_q;
    assign head_ent    = ent_q[head_q];
    assign commit_fire = rdy_in && !flush_q && busy_q[head_q] && ready_q[head_q];
    assign mispredict  = is_branch(head_ent.op) && (taken_q[head_q] != head_ent.pred_taken);

    reorder_buffer_lookup u_lookup1 (
        .label(label1), .busy(busy_q), .ready(ready_q), .vals(val_q),
        .rs_en(rs_cdb_en), .rs_lab(rs_cdb2lab), .rs_val(rs_cdb2val),
        .lsb_en(lsb_cdb_en), .lsb_lab(lsb_cdb2lab), .lsb_val(lsb_cdb2val),
        .hit(ready1), .val(res1)
    );

    reorder_buffer_lookup u_lookup2 (
        .label(label2), .busy(busy_q), .ready(ready_q), .vals(val_q),
        .rs_en(rs_cdb_en), .rs_lab(rs_cdb2lab), .rs_val(rs_cdb2val),
        .lsb_en(lsb_cdb_en), .lsb_lab(lsb_cdb2lab), .lsb_val(lsb_cdb2val),
        .hit(ready2), .val(res2)
    );

    // Next state: stall holds everything, flush empties the buffer, otherwise capture/commit/issue.
    always_comb begin
        busy_d         = busy_q;
        ready_d        = ready_q;
        taken_d        = taken_q;
        val_d          = val_q;
        ent_d          = ent_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_en_d    = 1'b0;
        commit_store_d = 1'b0;
        flush_d        = 1'b0;
        commit_lab_d   = commit_lab_q;
        commit_val_d   = commit_val_q;
        commit_rd_d    = commit_rd_q;
        flush_pc_d     = flush_pc_q;
        if (rdy_in) begin
            if (flush_q) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                busy_d  = '0;
                ready_d = '0;
            end else begin
                // RS is applied last so it wins when both CDBs carry the same tag.
                for (int i = 0; i < ROB_SIZE; i++) begin
                    if (lsb_cdb_en && lsb_cdb2lab == tag_of(i) && busy_q[i]) begin
                        ready_d[i] = 1'b1;
                        val_d[i]   = lsb_cdb2val;
                    end
                    if (rs_cdb_en && rs_cdb2lab == tag_of(i) && busy_q[i]) begin
                        ready_d[i] = 1'b1;
                        val_d[i]   = rs_cdb2val;
                        taken_d[i] = rs_cdb_taken;
                    end
                end
                if (commit_fire) begin
                    busy_d[head_q]  = 1'b0;
                    ready_d[head_q] = 1'b0;
                    head_d          = head_q + IDX_W'(1);
                    commit_en_d     = 1'b1;
                    commit_lab_d    = ROB_ID_WIDTH'(head_q) + ROB_ID_WIDTH'(1);
                    commit_val_d    = val_q[head_q];
                    commit_rd_d     = mispredict ? 5'd0 : head_ent.rd;
                    commit_store_d  = is_store(head_ent.op);
                    if (mispredict) begin
                        flush_d    = 1'b1;
                        flush_pc_d = head_ent.alt_pc;
                    end
                end
                if (issue_ok) begin
                    busy_d[tail_q]           = 1'b1;
                    ready_d[tail_q]          = 1'b0;
                    taken_d[tail_q]          = 1'b0;
                    ent_d[tail_q].op         = issue_type;
                    ent_d[tail_q].rd         = issue_rd;
                    ent_d[tail_q].pred_taken = issue_pred_taken;
                    ent_d[tail_q].alt_pc     = issue_alt_pc;
                    tail_d                   = tail_q + IDX_W'(1);
                end
                count_d = count_q + {{(ROB_ID_WIDTH-1){1'b0}}, issue_ok}
                                  - {{(ROB_ID_WIDTH-1){1'b0}}, commit_fire};
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            busy_q         <= '0;
            ready_q        <= '0;
            taken_q        <= '0;
            val_q          <= '0;
            ent_q          <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_en_q    <= 1'b0;
            commit_store_q <= 1'b0;
            flush_q        <= 1'b0;
            commit_lab_q   <= '0;
            commit_val_q   <= '0;
            commit_rd_q    <= '0;
            flush_pc_q     <= '0;
        end else begin
            busy_q         <= busy_d;
            ready_q        <= ready_d;
            taken_q        <= taken_d;
            val_q          <= val_d;
            ent_q          <= ent_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_en_q    <= commit_en_d;
            commit_store_q <= commit_store_d;
            flush_q        <= flush_d;
            commit_lab_q   <= commit_lab_d;
            commit_val_q   <= commit_val_d;
            commit_rd_q    <= commit_rd_d;
            flush_pc_q     <= flush_pc_d;
        end
    end

    assign commit_en    = commit_en_q;
    assign commit_lab   = commit_lab_q;
    assign commit_val   = commit_val_q;
    assign commit_rd    = commit_rd_q;
    assign commit_store = commit_store_q;
    assign flush        = flush_q;
    assign flush_pc     = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: issued ops push expected commits, a negedge monitor checks them.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, dec2rob_en, issue_pred_taken;
    logic [5:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc;
    logic [3:0]  newTag, label1, label2, rs_cdb2lab, lsb_cdb2lab, commit_lab;
    logic        isFull, ready1, ready2, rs_cdb_en, rs_cdb_taken, lsb_cdb_en;
    logic [31:0] res1, res2, rs_cdb2val, lsb_cdb2val, commit_val, flush_pc;
    logic        commit_en, commit_store, flush;
    logic [4:0]  commit_rd;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .dec2rob_en(dec2rob_en),
        .issue_type(issue_type), .issue_rd(issue_rd), .issue_pred_taken(issue_pred_taken),
        .issue_alt_pc(issue_alt_pc), .newTag(newTag), .isFull(isFull),
        .label1(label1), .label2(label2), .ready1(ready1), .ready2(ready2),
        .res1(res1), .res2(res2),
        .rs_cdb_en(rs_cdb_en), .rs_cdb2lab(rs_cdb2lab), .rs_cdb2val(rs_cdb2val),
        .rs_cdb_taken(rs_cdb_taken),
        .lsb_cdb_en(lsb_cdb_en), .lsb_cdb2lab(lsb_cdb2lab), .lsb_cdb2val(lsb_cdb2val),
        .commit_en(commit_en), .commit_lab(commit_lab), .commit_val(commit_val),
        .commit_rd(commit_rd), .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc)
    );

    typedef struct {
        logic [3:0]  lab;
        logic [31:0] val;
        logic [4:0]  rd;
        logic        store;
        logic        fl;
        logic [31:0] pc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] nt;
    bit         mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; the expected commit record is queued with the tag the bench predicts.
    task automatic issue(input op_t op, input logic [4:0] rd, input logic pred,
                         input logic [31:0] alt, input logic [31:0] v,
                         input logic st, input logic fl);
        exp_t e;
        chk("newTag", {28'd0, newTag}, {28'd0, nt});
        dec2rob_en = 1'b1; issue_type = op; issue_rd = rd;
        issue_pred_taken = pred; issue_alt_pc = alt;
        e.lab = nt; e.val = v; e.rd = fl ? 5'd0 : rd; e.store = st; e.fl = fl; e.pc = alt;
        exp_q.push_back(e);
        step();
        dec2rob_en = 1'b0;
        nt = (nt == 4'd8) ? 4'd1 : nt + 4'd1;
    endtask

    task automatic cdb(input logic re, input logic [3:0] rl, input logic [31:0] rv, input logic rt,
                       input logic le, input logic [3:0] ll, input logic [31:0] lv);
        rs_cdb_en = re; rs_cdb2lab = rl; rs_cdb2val = rv; rs_cdb_taken = rt;
        lsb_cdb_en = le; lsb_cdb2lab = ll; lsb_cdb2val = lv;
        step();
        rs_cdb_en = 1'b0; lsb_cdb_en = 1'b0;
    endtask

    // Monitor: every commit pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (mon_on) begin
            if (commit_en) begin
                if (exp_q.size() == 0) begin
                    chk("commit_unexpected", {31'd0, commit_en}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("commit_lab", {28'd0, commit_lab}, {28'd0, mon_e.lab});
                    chk("commit_val", commit_val, mon_e.val);
                    chk("commit_rd", {27'd0, commit_rd}, {27'd0, mon_e.rd});
                    chk("commit_store", {31'd0, commit_store}, {31'd0, mon_e.store});
                    chk("commit_flush", {31'd0, flush}, {31'd0, mon_e.fl});
                    if (mon_e.fl) chk("flush_pc", flush_pc, mon_e.pc);
                end
            end else if (flush) begin
                chk("flush_without_commit", {31'd0, flush}, 32'd0);
            end
        end
    end

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; dec2rob_en = 1'b0; issue_type = OP_NOP; issue_rd = 5'd0;
        issue_pred_taken = 1'b0; issue_alt_pc = 32'd0; label1 = 4'd0; label2 = 4'd0;
        rs_cdb_en = 1'b0; rs_cdb2lab = 4'd0; rs_cdb2val = 32'd0; rs_cdb_taken = 1'b0;
        lsb_cdb_en = 1'b0; lsb_cdb2lab = 4'd0; lsb_cdb2val = 32'd0;
        nt = 4'd1;
        step(); step();
        chk("rst_newTag", {28'd0, newTag}, 32'd1);
        chk("rst_isFull", {31'd0, isFull}, 32'd0);
        chk("rst_commit_en", {31'd0, commit_en}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_commit_store", {31'd0, commit_store}, 32'd0);
        chk("rst_commit_lab", {28'd0, commit_lab}, 32'd0);
        chk("rst_commit_val", commit_val, 32'd0);
        chk("rst_commit_rd", {27'd0, commit_rd}, 32'd0);
        chk("rst_flush_pc", flush_pc, 32'd0);
        rst_in = 1'b1;
        mon_on = 1'b1;

        // Three issues, then out-of-order completion 2 before 1.
        issue(OP_ADD, 5'd5, 1'b0, 32'd0, 32'h2A, 1'b0, 1'b0);
        issue(OP_ADD, 5'd6, 1'b0, 32'd0, 32'h22, 1'b0, 1'b0);
        issue(OP_ADD, 5'd7, 1'b0, 32'd0, 32'h99, 1'b0, 1'b0);
        chk("newTag_after3", {28'd0, newTag}, 32'd4);
        chk("isFull_after3", {31'd0, isFull}, 32'd0);
        chk("no_commit_yet", {31'd0, commit_en}, 32'd0);
        label1 = 4'd1;
        #1 chk("ready1_pending", {31'd0, ready1}, 32'd0);
        cdb(1'b1, 4'd2, 32'h22, 1'b0, 1'b0, 4'd0, 32'd0);
        rs_cdb_en = 1'b1; rs_cdb2lab = 4'd1; rs_cdb2val = 32'h2A;
        label1 = 4'd2; label2 = 4'd1;
        #1;
        chk("ready1_entry", {31'd0, ready1}, 32'd1);
        chk("res1_entry", res1, 32'h22);
        chk("ready2_rsbypass", {31'd0, ready2}, 32'd1);
        chk("res2_rsbypass", res2, 32'h2A);
        step();
        rs_cdb_en = 1'b0;
        lsb_cdb_en = 1'b1; lsb_cdb2lab = 4'd3; lsb_cdb2val = 32'h99;
        label1 = 4'd3; label2 = 4'd0;
        #1;
        chk("ready1_lsbbypass", {31'd0, ready1}, 32'd1);
        chk("res1_lsbbypass", res1, 32'h99);
        chk("ready2_label0", {31'd0, ready2}, 32'd0);
        chk("res2_label0", res2, 32'd0);
        step();
        lsb_cdb_en = 1'b0; label1 = 4'd0;
        repeat (4) step();

        // Fill all eight slots (tags wrap 4..8,1..3), then try to issue while full.
        issue(OP_ADD, 5'd8,  1'b0, 32'd0, 32'h40, 1'b0, 1'b0);
        issue(OP_ADD, 5'd9,  1'b0, 32'd0, 32'h55, 1'b0, 1'b0);
        issue(OP_ADD, 5'd10, 1'b0, 32'd0, 32'h60, 1'b0, 1'b0);
        issue(OP_LW,  5'd11, 1'b0, 32'd0, 32'h70, 1'b0, 1'b0);
        issue(OP_SW,  5'd0,  1'b0, 32'd0, 32'h80, 1'b1, 1'b0);
        issue(OP_ADD, 5'd12, 1'b0, 32'd0, 32'h11, 1'b0, 1'b0);
        issue(OP_ADD, 5'd13, 1'b0, 32'd0, 32'h12, 1'b0, 1'b0);
        issue(OP_ADD, 5'd14, 1'b0, 32'd0, 32'h13, 1'b0, 1'b0);
        chk("isFull_8", {31'd0, isFull}, 32'd1);
        chk("newTag_full", {28'd0, newTag}, 32'd4);
        cdb(1'b1, 4'd4, 32'h40, 1'b0, 1'b0, 4'd0, 32'd0);
        dec2rob_en = 1'b1; issue_type = OP_ADD; issue_rd = 5'd20;
        #1 chk("isFull_before_commit", {31'd0, isFull}, 32'd1);
        step();
        dec2rob_en = 1'b0;
        chk("isFull_after_commit", {31'd0, isFull}, 32'd0);
        chk("newTag_issue_blocked", {28'd0, newTag}, 32'd4);
        cdb(1'b1, 4'd5, 32'h55, 1'b0, 1'b1, 4'd5, 32'h66);
        cdb(1'b1, 4'd6, 32'h60, 1'b0, 1'b1, 4'd7, 32'h70);
        cdb(1'b0, 4'd0, 32'd0,  1'b0, 1'b1, 4'd8, 32'h80);
        cdb(1'b1, 4'd1, 32'h11, 1'b0, 1'b0, 4'd0, 32'd0);
        cdb(1'b1, 4'd2, 32'h12, 1'b0, 1'b0, 4'd0, 32'd0);
        cdb(1'b1, 4'd3, 32'h13, 1'b0, 1'b0, 4'd0, 32'd0);
        repeat (3) step();

        // JAL and a correctly predicted branch commit without flushing.
        issue(OP_JAL, 5'd1, 1'b0, 32'h500, 32'h44, 1'b0, 1'b0);
        cdb(1'b1, 4'd4, 32'h44, 1'b1, 1'b0, 4'd0, 32'd0);
        issue(OP_BNE, 5'd0, 1'b1, 32'h600, 32'd0, 1'b0, 1'b0);
        cdb(1'b1, 4'd5, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0);
        repeat (3) step();

        // Mispredicted branch (tag 6) with a ready younger op (tag 7) that must be squashed.
        issue(OP_BEQ, 5'd0, 1'b0, 32'h100, 32'd0, 1'b0, 1'b1);
        chk("newTag_young", {28'd0, newTag}, 32'd7);
        dec2rob_en = 1'b1; issue_type = OP_ADD; issue_rd = 5'd9;
        step();
        dec2rob_en = 1'b0;
        cdb(1'b1, 4'd7, 32'h77, 1'b0, 1'b0, 4'd0, 32'd0);
        cdb(1'b1, 4'd6, 32'd0,  1'b1, 1'b0, 4'd0, 32'd0);
        step();
        chk("flush_pulse", {31'd0, flush}, 32'd1);
        chk("flush_pc_val", flush_pc, 32'h100);
        dec2rob_en = 1'b1; issue_type = OP_ADD; issue_rd = 5'd4;
        step();
        dec2rob_en = 1'b0;
        chk("flush_one_cycle", {31'd0, flush}, 32'd0);
        chk("newTag_after_flush", {28'd0, newTag}, 32'd1);
        chk("isFull_after_flush", {31'd0, isFull}, 32'd0);
        nt = 4'd1;

        // Global stall freezes a ready head until rdy_in returns.
        issue(OP_ADD, 5'd3, 1'b0, 32'd0, 32'h3C, 1'b0, 1'b0);
        cdb(1'b1, 4'd1, 32'h3C, 1'b0, 1'b0, 4'd0, 32'd0);
        rdy_in = 1'b0;
        step();
        chk("stall_commit_en_a", {31'd0, commit_en}, 32'd0);
        step();
        chk("stall_commit_en_b", {31'd0, commit_en}, 32'd0);
        rdy_in = 1'b1;
        step();
        chk("commit_after_stall", {31'd0, commit_en}, 32'd1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
